// File: rtl/dlsc_uart_pkg.sv
// Shared constants and types for the buffered UART receiver.
// Parity modes, FSM state encoding and the FIFO entry width helper.
package dlsc_uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // FIFO entry is {parity_err, frame_err, data}
  function automatic int entry_width(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/dlsc_uart_baudgen.sv
// Fractional baud tick generator: period cfg_div, plus one cycle whenever
// the fractional accumulator carries. A cfg change restarts both counters.
module dlsc_uart_baudgen #(
  parameter int DIV_BITS  = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_BITS-1:0]  cfg_div,
  input  logic [FRAC_BITS-1:0] cfg_frac,
  output logic                 tick
);

  logic [DIV_BITS-1:0]  cnt_q, cnt_d;
  logic [FRAC_BITS-1:0] acc_q, acc_d;
  logic                 extra_q, extra_d;
  logic [DIV_BITS-1:0]  div_q;
  logic [FRAC_BITS-1:0] frac_q;
  logic [DIV_BITS:0]    last;
  logic                 cfg_chg;

  always_comb begin
    cfg_chg = (cfg_div != div_q) || (cfg_frac != frac_q);
    last    = {1'b0, cfg_div} + {{DIV_BITS{1'b0}}, extra_q} - {{DIV_BITS{1'b0}}, 1'b1};
    tick    = (cfg_div != '0) && !cfg_chg && ({1'b0, cnt_q} == last);
    cnt_d   = cnt_q + {{(DIV_BITS-1){1'b0}}, 1'b1};
    acc_d   = acc_q;
    extra_d = extra_q;
    if (cfg_chg || (cfg_div == '0)) begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
    end else if (tick) begin
      cnt_d              = '0;
      {extra_d, acc_d}   = {1'b0, acc_q} + {1'b0, cfg_frac};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      extra_q <= 1'b0;
      div_q   <= '0;
      frac_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      extra_q <= extra_d;
      div_q   <= cfg_div;
      frac_q  <= cfg_frac;
    end
  end

endmodule

// File: rtl/dlsc_uart_rx_buffered.sv
// UART receiver with programmable fractional baud, 3-sample majority voting
// and a first-word-fall-through receive FIFO with overrun reporting.
module dlsc_uart_rx_buffered
  import dlsc_uart_pkg::*;
#(
  parameter int START      = 1,
  parameter int STOP       = 1,
  parameter int DATA       = 8,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_BITS   = 16,
  parameter int FRAC_BITS  = 8,
  parameter int FIFO_ADDR  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_BITS-1:0]  cfg_div,
  input  logic [FRAC_BITS-1:0] cfg_frac,
  input  logic                 rx,
  input  logic                 rx_mask,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA-1:0]      out_data,
  output logic                 out_frame_error,
  output logic                 out_parity_error,
  output logic                 overrun,
  output logic [FIFO_ADDR:0]   fifo_count
);

  localparam int EW    = entry_width(DATA);
  localparam int DEPTH = 1 << FIFO_ADDR;
  localparam int CW    = $clog2(OVERSAMPLE);
  localparam int BW    = 4;
  localparam logic [CW-1:0] S_LO  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] S_MID = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] S_HI  = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] S_END = CW'(OVERSAMPLE - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic tick;

  dlsc_uart_baudgen #(
    .DIV_BITS  (DIV_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_baudgen (
    .clk      (clk),
    .rst      (rst),
    .cfg_div  (cfg_div),
    .cfg_frac (cfg_frac),
    .tick     (tick)
  );

  logic [1:0] sync_q, sync_d;
  logic       rx_s;

  always_comb begin
    sync_d = {sync_q[0], rx};
    rx_s   = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= sync_d;
  end

  rx_state_t         state_q;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     bit_q;
  logic [1:0]        samp_q;
  logic              armed_q, frame_err_q, par_err_q, push_q;
  logic [DATA-1:0]   shift_q;
  logic [EW-1:0]     entry_q;
  logic              bit_v, par_exp, fe_stop;

  always_comb begin
    bit_v   = maj3(samp_q[0], samp_q[1], rx_s);
    par_exp = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;
    fe_stop = frame_err_q | ~bit_v;
  end

  // armed_q keeps a held-low line (break) from restarting until rx returns high
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      samp_q      <= '0;
      armed_q     <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      push_q      <= 1'b0;
      shift_q     <= '0;
      entry_q     <= '0;
    end else begin
      push_q <= 1'b0;
      if (rx_s) armed_q <= 1'b1;
      if (state_q != ST_IDLE && rx_mask) begin
        state_q <= ST_IDLE;
      end else if (tick) begin
        if (state_q == ST_IDLE) begin
          if (armed_q && !rx_s && !rx_mask) begin
            state_q     <= ST_START;
            cnt_q       <= CW'(1);
            bit_q       <= '0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == S_LO)  samp_q[0] <= rx_s;
          if (cnt_q == S_MID) samp_q[1] <= rx_s;
          if (cnt_q == S_HI) begin
            case (state_q)
              ST_START: if (bit_v) begin
                if (bit_q == '0) state_q <= ST_IDLE;
                else             frame_err_q <= 1'b1;
              end
              ST_DATA:   shift_q   <= {bit_v, shift_q[DATA-1:1]};
              ST_PARITY: par_err_q <= (bit_v != par_exp);
              ST_STOP: begin
                frame_err_q <= fe_stop;
                if (bit_q == BW'(STOP-1)) begin
                  state_q <= ST_IDLE;
                  push_q  <= 1'b1;
                  entry_q <= {par_err_q, fe_stop, shift_q};
                  armed_q <= 1'b0;
                end
              end
              default: ;
            endcase
          end
          if (cnt_q == S_END) begin
            cnt_q <= '0;
            bit_q <= bit_q + BW'(1);
            case (state_q)
              ST_START: if (bit_q == BW'(START-1)) begin
                state_q <= ST_DATA;
                bit_q   <= '0;
              end
              ST_DATA: if (bit_q == BW'(DATA-1)) begin
                state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                bit_q   <= '0;
              end
              ST_PARITY: begin
                state_q <= ST_STOP;
                bit_q   <= '0;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  logic [EW-1:0]        mem_q [DEPTH];
  logic [FIFO_ADDR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR:0]   count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 empty, full, pop, wr_en;
  logic [EW-1:0]        head;

  // A full FIFO still accepts a push when the head is popped in the same cycle
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == (FIFO_ADDR+1)'(DEPTH));
    pop       = !empty && out_ready;
    wr_en     = push_q && (!full || pop);
    overrun_d = push_q && !wr_en;
    wr_ptr_d  = wr_ptr_q + FIFO_ADDR'(wr_en);
    rd_ptr_d  = rd_ptr_q + FIFO_ADDR'(pop);
    count_d   = count_q + (FIFO_ADDR+1)'(wr_en) - (FIFO_ADDR+1)'(pop);
    head      = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= entry_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid        = !empty;
  assign out_data         = head[DATA-1:0];
  assign out_frame_error  = head[DATA];
  assign out_parity_error = head[DATA+1];
  assign overrun          = overrun_q;
  assign fifo_count       = count_q;

endmodule

// File: doc/dlsc_uart_rx_buffered.md
Name: dlsc_uart_rx_buffered

Overview:
Self-contained UART receiver with a run-time programmable fractional baud generator, 3-sample majority-vote bit sampling with start-glitch rejection, and a ready/valid receive FIFO with overrun reporting. It is the next-generation replacement for the fixed-frequency rx core plus clock-synth pairing. Software can retune the baud rate without re-synthesis, and bursts are absorbed without data loss up to the FIFO depth.

Parameters:
START, 1, number of start bits (1..2)
STOP, 1, number of stop bits (1..2)
DATA, 8, data bits per frame, LSB first (5..9)
PARITY, 0, 0=none, 1=odd, 2=even
OVERSAMPLE, 16, baud ticks per bit (8..32, even)
DIV_BITS, 16, width of integer divisor
FRAC_BITS, 8, width of fractional divisor
FIFO_ADDR, 4, log2 of FIFO depth (depth 16)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
cfg_div  input  DIV_BITS  integer clk cycles per baud tick; 0 halts the generator
cfg_frac  input  FRAC_BITS  fractional cycles per tick, in units of 2^-FRAC_BITS
rx  input  1  asynchronous serial input; idle high
rx_mask  input  1  disable reception while high
out_ready  input  1  consumer ready
out_valid  output  1  FIFO non-empty
out_data  output  DATA  head entry data
out_frame_error  output  1  head entry start/stop error
out_parity_error  output  1  head entry parity error
overrun  output  1  1-cycle pulse when a frame is dropped on a full FIFO
fifo_count  output  FIFO_ADDR+1  occupancy, 0..2^FIFO_ADDR

Behaviour:
- Reset: all outputs are 0, FIFO is empty, FSM is in IDLE, and the generator accumulators are cleared.
- Baud generator:
  - The integer counter emits tick and reloads after cfg_div cycles, plus 1 extra cycle whenever the FRAC_BITS accumulator carries on adding cfg_frac.
  - Average tick period is cfg_div + cfg_frac/2^FRAC_BITS.
  - Any change of cfg_div/cfg_frac clears both counters the next cycle.
  - cfg_div of 1 with cfg_frac 0 ticks every cycle.
- rx passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- FSM states: IDLE, START, DATA, PARITY, STOP. A per-bit tick counter runs 0..OVERSAMPLE-1, and the bit value is the majority of the samples at counts OVERSAMPLE/2-1, /2 and /2+1.
  - IDLE -> START: on a tick where rx is low and rx_mask is low.
  - START: if the majority of the first start bit is 1, return to IDLE with no push (glitch). Later start bits that are not 0 set frame_err.
  - DATA: shift DATA bits, LSB first.
  - PARITY: only when PARITY != 0. parity_err = received bit != computed bit (odd: XOR of data inverted; even: XOR of data).
  - STOP: any stop bit sampled 0 sets frame_err. After the last stop-bit majority decision, push {parity_err, frame_err, data} and go to IDLE immediately, without waiting out the stop bit.
- Break (rx held low) produces data 0, frame_error=1. The FSM stays in IDLE until rx is sampled high, so there is no repeat push.
- rx_mask high mid-frame aborts the frame: go to IDLE, no push, no overrun.
- Latency: the push occurs the cycle after the final majority decision, and out_valid rises the following cycle.
- FIFO:
  - First-word-fall-through. Pop occurs when out_valid && out_ready.
  - Push when full is dropped and pulses overrun. Push and pop in the same cycle when full is accepted, with no overrun.
  - When empty, out_data and the error flags are forced to 0.
  - fifo_count is registered and exact.
- Reset asserted mid-frame or mid-FIFO discards everything.

Decomposition:
- Package dlsc_uart_pkg holds:
  - parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN)
  - FSM state encoding
  - an entry-width function DATA+2
- One sub-module, dlsc_uart_baudgen: the fractional tick generator with inputs cfg_div/cfg_frac and output tick.
- The FIFO is inline: a register array plus pointers.

Test Plan:
1. 8N1, cfg_div=54, cfg_frac=64 (115200 baud x16 at 100 MHz), send 0x55 -> out_valid with data 0x55, both errors 0, fifo_count 1; out_ready=1 pops it and fifo_count returns to 0.
2. PARITY=2, send 0xA3 with parity bit 1 (wrong) -> data 0xA3, parity_error=1; same byte with parity bit 0 -> parity_error=0.
3. Hold rx low for 20 bit times, then release -> exactly one entry with data 0x00, frame_error=1; the next valid 0x7E is received cleanly.
4. rx low pulse of 4 ticks (shorter than half a bit) -> no entry, FSM back in IDLE, fifo_count 0.
5. out_ready=0, send 17 bytes 0x00..0x10 -> fifo_count 16, one overrun pulse on the 17th; draining yields 0x00..0x0F in order.
6. rx_mask raised during DATA, then lowered and 0x3C sent -> only 0x3C is pushed. Repeat with rst low mid-frame: FIFO empties and the next byte is received correctly.
